// File: rtl/accelerator_top_vector_driver.sv
// Host-side X/Y vector driver for accelerator_top: serves X_IN on request, captures Y_OUT, reports done.
// Optional watchdog: define ACCELERATOR_TOP_VECTOR_DRIVER_TIMEOUT_EN to abort a stalled run after TIMEOUT cycles.
//
// state   | meaning
// IDLE    | waiting for HOST_START; X buffer writable
// START_P | START pulse to the top
// RUN     | serving X requests, capturing Y, waiting for READY
// DONE    | one-cycle HOST_DONE pulse
module accelerator_top_vector_driver #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int DEPTH        = 64,
  parameter int ADDR_SIZE    = 6,
  parameter int TIMEOUT      = 1024
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    HOST_START,
  output logic                    HOST_BUSY,
  output logic                    HOST_DONE,
  output logic                    HOST_ERROR,
  input  logic [CONTROL_SIZE-1:0] HOST_SIZE_X,
  input  logic [CONTROL_SIZE-1:0] HOST_SIZE_Y,
  input  logic                    X_WR_ENABLE,
  input  logic [ADDR_SIZE-1:0]    X_WR_ADDR,
  input  logic [DATA_SIZE-1:0]    X_WR_DATA,
  input  logic [ADDR_SIZE-1:0]    Y_RD_ADDR,
  output logic [DATA_SIZE-1:0]    Y_RD_DATA,
  output logic [CONTROL_SIZE-1:0] Y_COUNT,
  output logic                    START,
  input  logic                    READY,
  output logic [DATA_SIZE-1:0]    SIZE_X_IN,
  output logic [DATA_SIZE-1:0]    SIZE_Y_IN,
  input  logic                    X_IN_ENABLE,
  output logic [DATA_SIZE-1:0]    X_IN,
  input  logic                    Y_OUT_ENABLE,
  input  logic [DATA_SIZE-1:0]    Y_OUT
);

  typedef enum logic [1:0] {S_IDLE, S_START_P, S_RUN, S_DONE} state_t;

  localparam logic [ADDR_SIZE:0]      DEPTH_A = (ADDR_SIZE+1)'(DEPTH);
  localparam logic [ADDR_SIZE:0]      ONE_A   = (ADDR_SIZE+1)'(1);
  localparam logic [CONTROL_SIZE-1:0] DEPTH_C = CONTROL_SIZE'(DEPTH);

  state_t state_q, state_d;

  logic [DATA_SIZE-1:0] x_buf [DEPTH];
  logic [DATA_SIZE-1:0] y_buf [DEPTH];

  logic [ADDR_SIZE-1:0] x_idx;
  logic [ADDR_SIZE-1:0] x_next;
  logic [ADDR_SIZE:0]   x_inc;
  logic [ADDR_SIZE:0]   y_idx;
  logic [ADDR_SIZE:0]   size_x_q;
  logic [ADDR_SIZE:0]   size_y_q;
  logic                 start_ok;
  logic                 x_take;
  logic                 y_room;
  logic                 y_take;
  logic                 y_drop;
  logic                 timeout_hit;

  // Zero or oversize lengths fall back to the full buffer.
  function automatic logic [ADDR_SIZE:0] clamp_size(input logic [CONTROL_SIZE-1:0] s);
    logic [ADDR_SIZE:0] r;
    if (s == '0 || s > DEPTH_C) r = DEPTH_A;
    else                        r = s[ADDR_SIZE:0];
    return r;
  endfunction

  assign start_ok = (state_q == S_IDLE) && HOST_START;
  assign x_take   = (state_q == S_RUN) && X_IN_ENABLE;
  assign y_room   = (y_idx < size_y_q);
  assign y_take   = (state_q == S_RUN) && Y_OUT_ENABLE && y_room;
  assign y_drop   = (state_q == S_RUN) && Y_OUT_ENABLE && !y_room;

  // X vector is reused every timestep, so the index wraps at the latched length.
  assign x_inc  = {1'b0, x_idx} + ONE_A;
  assign x_next = (x_inc == size_x_q) ? '0 : x_inc[ADDR_SIZE-1:0];

`ifdef ACCELERATOR_TOP_VECTOR_DRIVER_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TMR_W-1:0] tmr_q;
  logic             activity;

  assign activity = X_IN_ENABLE || Y_OUT_ENABLE || READY;

  always_ff @(posedge CLK) begin
    if (RST)                                 tmr_q <= '0;
    else if (state_q != S_RUN || activity)   tmr_q <= TMR_W'(TIMEOUT - 1);
    else if (tmr_q != '0)                    tmr_q <= tmr_q - TMR_W'(1);
  end

  assign timeout_hit = (state_q == S_RUN) && !activity && (tmr_q == '0);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    START     = 1'b0;
    HOST_DONE = 1'b0;
    HOST_BUSY = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:    if (HOST_START) state_d = S_START_P;
      S_START_P: begin
        START   = 1'b1;
        state_d = S_RUN;
      end
      S_RUN:     if (READY || timeout_hit) state_d = S_DONE;
      S_DONE: begin
        HOST_DONE = 1'b1;
        state_d   = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      x_idx      <= '0;
      y_idx      <= '0;
      size_x_q   <= '0;
      size_y_q   <= '0;
      X_IN       <= '0;
      HOST_ERROR <= 1'b0;
      Y_RD_DATA  <= '0;
    end else begin
      Y_RD_DATA <= y_buf[Y_RD_ADDR];
      if (start_ok) begin
        size_x_q   <= clamp_size(HOST_SIZE_X);
        size_y_q   <= clamp_size(HOST_SIZE_Y);
        x_idx      <= '0;
        y_idx      <= '0;
        HOST_ERROR <= 1'b0;
        X_IN       <= x_buf[0];
      end else begin
        if (x_take) begin
          x_idx <= x_next;
          X_IN  <= x_buf[x_next];
        end
        if (y_take) y_idx <= y_idx + ONE_A;
        if (y_drop || timeout_hit) HOST_ERROR <= 1'b1;
      end
    end
  end

  // Buffers are storage only; reset leaves their contents alone.
  always_ff @(posedge CLK) begin
    if (!RST && X_WR_ENABLE && state_q == S_IDLE) x_buf[X_WR_ADDR] <= X_WR_DATA;
    if (!RST && y_take) y_buf[y_idx[ADDR_SIZE-1:0]] <= Y_OUT;
  end

  assign Y_COUNT   = CONTROL_SIZE'(y_idx);
  assign SIZE_X_IN = DATA_SIZE'(size_x_q);
  assign SIZE_Y_IN = DATA_SIZE'(size_y_q);

endmodule

// File: tb/tb_accelerator_top_vector_driver.sv
// Bench for accelerator_top_vector_driver: directed and randomized runs against a vector-level reference model.
module tb_accelerator_top_vector_driver;

  localparam int DS    = 64;
  localparam int CS    = 64;
  localparam int DEPTH = 64;
  localparam int AS    = 6;
  localparam int TO    = 16;

  logic          CLK, RST, HOST_START, HOST_BUSY, HOST_DONE, HOST_ERROR;
  logic [CS-1:0] HOST_SIZE_X, HOST_SIZE_Y, Y_COUNT;
  logic          X_WR_ENABLE;
  logic [AS-1:0] X_WR_ADDR, Y_RD_ADDR;
  logic [DS-1:0] X_WR_DATA, Y_RD_DATA;
  logic          START, READY, X_IN_ENABLE, Y_OUT_ENABLE;
  logic [DS-1:0] SIZE_X_IN, SIZE_Y_IN, X_IN, Y_OUT;

  int checks   = 0;
  int failures = 0;

  logic [DS-1:0] x_model [DEPTH];
  logic [DS-1:0] y_model [DEPTH];
  bit            y_known [DEPTH];
  logic [DS-1:0] yq [$];
  int            m_cnt;
  bit            m_err;
  logic [DS-1:0] x_in_exp;

  accelerator_top_vector_driver #(
    .DATA_SIZE(DS), .CONTROL_SIZE(CS), .DEPTH(DEPTH), .ADDR_SIZE(AS), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .RST(RST), .HOST_START(HOST_START), .HOST_BUSY(HOST_BUSY),
    .HOST_DONE(HOST_DONE), .HOST_ERROR(HOST_ERROR), .HOST_SIZE_X(HOST_SIZE_X),
    .HOST_SIZE_Y(HOST_SIZE_Y), .X_WR_ENABLE(X_WR_ENABLE), .X_WR_ADDR(X_WR_ADDR),
    .X_WR_DATA(X_WR_DATA), .Y_RD_ADDR(Y_RD_ADDR), .Y_RD_DATA(Y_RD_DATA),
    .Y_COUNT(Y_COUNT), .START(START), .READY(READY), .SIZE_X_IN(SIZE_X_IN),
    .SIZE_Y_IN(SIZE_Y_IN), .X_IN_ENABLE(X_IN_ENABLE), .X_IN(X_IN),
    .Y_OUT_ENABLE(Y_OUT_ENABLE), .Y_OUT(Y_OUT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit observed=running required=finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clampv(input logic [63:0] s);
    if (s == 0 || s > 64) return 64;
    return int'(s);
  endfunction

  task automatic check_reset_outputs();
    chk("rst_busy", HOST_BUSY, 0);
    chk("rst_done", HOST_DONE, 0);
    chk("rst_error", HOST_ERROR, 0);
    chk("rst_start", START, 0);
    chk("rst_x_in", X_IN, 0);
    chk("rst_y_count", Y_COUNT, 0);
    chk("rst_size_x_in", SIZE_X_IN, 0);
    chk("rst_size_y_in", SIZE_Y_IN, 0);
    chk("rst_y_rd_data", Y_RD_DATA, 0);
  endtask

  task automatic write_x(input int a, input logic [63:0] d);
    X_WR_ENABLE = 1'b1;
    X_WR_ADDR   = AS'(a);
    X_WR_DATA   = d;
    @(negedge CLK);
    X_WR_ENABLE = 1'b0;
  endtask

  task automatic readback();
    for (int i = 0; i < DEPTH; i++) begin
      if (y_known[i]) begin
        Y_RD_ADDR = AS'(i);
        @(negedge CLK);
        chk("y_buf_read", Y_RD_DATA, y_model[i]);
      end
    end
  endtask

  // One host run; yq holds the Y elements the top will present.
  task automatic do_run(input logic [63:0] sx, input logic [63:0] sy, input int nx,
                        input bit serial, input bit ready_with_y, input bit inject);
    int sxe, sye, xk, yi, it;
    bit x_en, y_en, last, ready_sent;
    sxe = clampv(sx);
    sye = clampv(sy);
    HOST_SIZE_X = sx;
    HOST_SIZE_Y = sy;
    HOST_START  = 1'b1;
    @(negedge CLK);
    HOST_START = 1'b0;
    chk("start_pulse", START, 1);
    chk("busy_after_start", HOST_BUSY, 1);
    chk("error_cleared", HOST_ERROR, 0);
    chk("count_cleared", Y_COUNT, 0);
    chk("size_x_in", SIZE_X_IN, sxe);
    chk("size_y_in", SIZE_Y_IN, sye);
    chk("x_in_first", X_IN, x_model[0]);
    @(negedge CLK);
    chk("start_one_cycle", START, 0);
    m_cnt = 0; m_err = 0; xk = 0; yi = 0; it = 0; ready_sent = 0;
    while ((xk < nx || yi < yq.size()) && it < 2000) begin
      if (serial) begin
        x_en = (xk < nx);
        y_en = !x_en;
      end else begin
        x_en = (xk < nx) && ($urandom_range(0, 3) != 0);
        y_en = (yi < yq.size()) && ($urandom_range(0, 2) != 0);
      end
      last = ((xk + int'(x_en)) >= nx) && ((yi + int'(y_en)) >= yq.size());
      X_IN_ENABLE = x_en;
      Y_OUT_ENABLE = y_en;
      READY = ready_with_y && last && y_en;
      ready_sent = ready_with_y && last && y_en;
      if (inject && it == 0) begin
        X_WR_ENABLE = 1'b1;
        X_WR_ADDR   = '0;
        X_WR_DATA   = ~x_model[0];
        HOST_START  = 1'b1;
      end
      chk("no_restart_in_run", START, 0);
      chk("busy_in_run", HOST_BUSY, 1);
      if (x_en) begin
        chk("x_in_sample", X_IN, x_model[xk % sxe]);
        xk++;
      end
      if (y_en) begin
        Y_OUT = yq[yi];
        if (m_cnt < sye) begin
          y_model[m_cnt] = yq[yi];
          y_known[m_cnt] = 1'b1;
          m_cnt++;
        end else begin
          m_err = 1'b1;
        end
        yi++;
      end
      @(negedge CLK);
      X_WR_ENABLE = 1'b0;
      HOST_START  = 1'b0;
      it++;
    end
    X_IN_ENABLE  = 1'b0;
    Y_OUT_ENABLE = 1'b0;
    if (!ready_sent) begin
      READY = 1'b1;
      @(negedge CLK);
    end
    READY = 1'b0;
    chk("done_after_ready", HOST_DONE, 1);
    chk("run_error", HOST_ERROR, m_err);
    chk("y_count", Y_COUNT, m_cnt);
    x_in_exp = x_model[xk % sxe];
    chk("x_in_hold", X_IN, x_in_exp);
    @(negedge CLK);
    chk("done_one_cycle", HOST_DONE, 0);
    chk("idle_after_done", HOST_BUSY, 0);
    yq.delete();
  endtask

  initial begin
    logic [63:0] sx, sy;
    int nx, ny, n;
    RST = 1'b1; HOST_START = 0; HOST_SIZE_X = 0; HOST_SIZE_Y = 0;
    X_WR_ENABLE = 0; X_WR_ADDR = 0; X_WR_DATA = 0; Y_RD_ADDR = 0;
    READY = 0; X_IN_ENABLE = 0; Y_OUT_ENABLE = 0; Y_OUT = 0;
    for (int i = 0; i < DEPTH; i++) y_known[i] = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check_reset_outputs();
    RST = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < DEPTH; i++) begin
      x_model[i] = {$urandom, $urandom};
      if (i < 4) x_model[i] = 64'(i + 1);
      write_x(i, x_model[i]);
    end

    // basic run
    yq.push_back(64'd10); yq.push_back(64'd20);
    do_run(64'd4, 64'd2, 4, 1'b1, 1'b0, 1'b0);
    readback();

    // X wrap at length 3
    do_run(64'd3, 64'd2, 6, 1'b1, 1'b0, 1'b0);

    // Y overflow: second element dropped, y_buf[1] keeps 20
    yq.push_back(64'd5); yq.push_back(64'd6);
    do_run(64'd4, 64'd1, 0, 1'b1, 1'b0, 1'b0);
    readback();

    // host writes and restart during RUN are ignored; size clamping
    yq.push_back({$urandom, $urandom});
    do_run(64'd0, 64'd100, 3, 1'b1, 1'b1, 1'b1);
    repeat (3) begin
      @(negedge CLK);
      chk("no_extra_done", HOST_DONE, 0);
    end

    // enables outside RUN do nothing
    X_IN_ENABLE = 1'b1; Y_OUT_ENABLE = 1'b1; Y_OUT = {$urandom, $urandom};
    @(negedge CLK);
    @(negedge CLK);
    X_IN_ENABLE = 1'b0; Y_OUT_ENABLE = 1'b0;
    chk("idle_x_in_hold", X_IN, x_in_exp);
    chk("idle_y_count_hold", Y_COUNT, m_cnt);
    chk("idle_error_hold", HOST_ERROR, m_err);
    chk("idle_not_busy", HOST_BUSY, 0);
    readback();

    // reset in the middle of a run
    HOST_SIZE_X = 64'd4; HOST_SIZE_Y = 64'd4; HOST_START = 1'b1;
    @(negedge CLK);
    HOST_START = 1'b0;
    @(negedge CLK);
    X_IN_ENABLE = 1'b1;
    @(negedge CLK);
    X_IN_ENABLE = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    check_reset_outputs();
    @(negedge CLK);
    check_reset_outputs();
    RST = 1'b0;
    n = 0;
    repeat (3) begin
      @(negedge CLK);
      chk("post_rst_no_done", HOST_DONE, 0);
      chk("post_rst_idle", HOST_BUSY, 0);
      n++;
    end
    chk("post_rst_x_in", X_IN, 0);

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      for (int w = 0; w < 2; w++) begin
        int a;
        a = $urandom_range(0, DEPTH - 1);
        x_model[a] = {$urandom, $urandom};
        write_x(a, x_model[a]);
      end
      sx = (r % 4 == 0) ? 64'd0 : 64'($urandom_range(1, 70));
      sy = (r == 3) ? 64'hFFFF_0000_0000_0002 : 64'($urandom_range(0, 9));
      ny = $urandom_range(0, ((clampv(sy) < 8) ? clampv(sy) : 8) + 2);
      for (int k = 0; k < ny; k++) yq.push_back({$urandom, $urandom});
      nx = $urandom_range(0, 20);
      do_run(sx, sy, nx, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end
    readback();

`ifdef ACCELERATOR_TOP_VECTOR_DRIVER_TIMEOUT_EN
    HOST_SIZE_X = 64'd4; HOST_SIZE_Y = 64'd4; HOST_START = 1'b1;
    @(negedge CLK);
    HOST_START = 1'b0;
    chk("timeout_start", START, 1);
    n = 0;
    while (n < 100 && HOST_DONE !== 1'b1) begin
      @(negedge CLK);
      n++;
    end
    chk("timeout_latency", (n >= TO && n <= TO + 1), 1);
    chk("timeout_error", HOST_ERROR, 1);
    @(negedge CLK);
    chk("timeout_idle", HOST_BUSY, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
